symbol_framer: RTL and testbench

Upstream feeder of the baseband DSP core. Buffers the serial payload bit stream in a small FIFO, pairs bits into QPSK symbols (first bit → I, second → Q), and emits one symbol every `SPS` clock cycles on `data_in_i`/`data_in_q` with a one-cycle `new_symbol` strobe. Each message is framed by a fixed preamble and a zero tail, and `msg_out` marks the active frame for the DSP core.

---
 rtl/symbol_framer.sv | 193 +++++++++++++++++++
 tb/tb_symbol_framer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/symbol_framer.sv
// symbol_framer: buffers a serial bit stream and frames it into QPSK symbols
//   (optional preamble, payload bit pairs, zero tail), one symbol every SPS cycles.
// Latency: msg_in sampled high in IDLE at edge k gives the first new_symbol after edge k+1.
// Backpressure: bit_ready = !full; the symbol side has no backpressure.
// Optional preamble: compiled in only when SYMBOL_FRAMER_PREAMBLE_EN is defined.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   bit_in/bit_valid      - payload bit input; accepted when bit_ready is high
//   bit_ready             - FIFO not full
//   msg_in                - level, source has a message
//   data_in_i/data_in_q   - registered symbol bits, valid while new_symbol is high
//   new_symbol            - one-cycle strobe per symbol
//   msg_out               - high from first to last symbol of a frame
//   underrun              - sticky: a payload slot found <2 bits while msg_in was high
//   fifo_count            - FIFO occupancy
module symbol_framer #(
    parameter int SPS          = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int PREAMBLE_LEN = 8,
    parameter int TAIL_LEN     = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    output logic                          bit_ready,
    input  logic                          msg_in,
    output logic                          data_in_i,
    output logic                          data_in_q,
    output logic                          new_symbol,
    output logic                          msg_out,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = $clog2(SPS);
    localparam int IDX_MAX = (PREAMBLE_LEN > TAIL_LEN) ? PREAMBLE_LEN : TAIL_LEN;
    localparam int IW      = $clog2(IDX_MAX + 1);

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, TAIL} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx, idx_nxt;     // preamble slot index, or tail symbol index
    logic [FIFO_DEPTH-1:0] mem;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;
    logic                push;
    logic [1:0]          pop_n;
    logic                older, newer;
    logic                slot;
    logic                sym_i, sym_q;
    logic                set_ur, clr_ur;

    assign bit_ready  = (count != (AW+1)'(FIFO_DEPTH));
    assign fifo_count = count;
    assign push       = bit_valid && bit_ready;
    assign older      = mem[rd_ptr];
    assign newer      = mem[rd_ptr + AW'(1)];
    assign slot       = (state != IDLE) && (cnt == '0);

    // Bit storage carries no reset; emptiness is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bit_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr + AW'(pop_n);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop_n);
        end
    end

    // Pop decisions look at count before any same-cycle push.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        pop_n     = 2'd0;
        sym_i     = 1'b0;
        sym_q     = 1'b0;
        set_ur    = 1'b0;
        clr_ur    = 1'b0;
        case (state)
            IDLE: begin
                if (msg_in) begin
`ifdef SYMBOL_FRAMER_PREAMBLE_EN
                    state_nxt = PREAMBLE;
`else
                    state_nxt = PAYLOAD;
`endif
                    idx_nxt   = '0;
                    clr_ur    = 1'b1;
                end
            end
            PREAMBLE: begin
                if (slot) begin
                    sym_i = ~idx[0];
                    sym_q = ~idx[0];
                    if (idx == IW'(PREAMBLE_LEN - 1)) begin
                        state_nxt = PAYLOAD;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end
            end
            PAYLOAD: begin
                if (slot) begin
                    if (count >= (AW+1)'(2)) begin
                        pop_n = 2'd2;
                        sym_i = older;
                        sym_q = newer;
                    end else if (msg_in) begin
                        set_ur = 1'b1;
                    end else if (count == (AW+1)'(1)) begin
                        // Odd leftover bit goes out with Q padded to 0.
                        pop_n     = 2'd1;
                        sym_i     = older;
                        state_nxt = TAIL;
                        idx_nxt   = '0;
                    end else begin
                        // This zero symbol already counts as tail symbol 0.
                        if (TAIL_LEN == 1) begin
                            state_nxt = IDLE;
                            idx_nxt   = '0;
                        end else begin
                            state_nxt = TAIL;
                            idx_nxt   = IW'(1);
                        end
                    end
                end
            end
            TAIL: begin
                if (slot) begin
                    if (idx == IW'(TAIL_LEN - 1)) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            new_symbol <= 1'b0;
            data_in_i  <= 1'b0;
            data_in_q  <= 1'b0;
            msg_out    <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            // Counter rests at 0 in IDLE so the first slot lands one edge after frame start.
            if (state == IDLE || state_nxt == IDLE) begin
                cnt <= '0;
            end else if (cnt == CW'(SPS - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            new_symbol <= slot;
            if (slot) begin
                data_in_i <= sym_i;
                data_in_q <= sym_q;
            end
            // Rises with the first strobe, falls the cycle after the last one.
            msg_out <= (state != IDLE) && (slot || msg_out);
            if (clr_ur) begin
                underrun <= 1'b0;
            end else if (set_ur) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_symbol_framer.sv
module tb_symbol_framer;

    localparam int SPS  = 8;
    localparam int TLEN = 2;
`ifdef SYMBOL_FRAMER_PREAMBLE_EN
    localparam int PRE = 8;
`else
    localparam int PRE = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       msg_in = 1'b0;
    logic       bit_ready, data_in_i, data_in_q, new_symbol, msg_out, underrun;
    logic [4:0] fifo_count;

    always #5 clk = ~clk;

    symbol_framer #(.SPS(SPS), .FIFO_DEPTH(16), .PREAMBLE_LEN(8), .TAIL_LEN(TLEN)) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .msg_in(msg_in), .data_in_i(data_in_i),
        .data_in_q(data_in_q), .new_symbol(new_symbol), .msg_out(msg_out),
        .underrun(underrun), .fifo_count(fifo_count)
    );

    typedef struct packed {
        logic i;
        logic q;
        logic u;
        logic last;
    } sym_t;

    sym_t  sb[$];
    sym_t  frame[$];
    int    total = 0;
    int    bad = 0;
    logic [15:0] pat = 16'hB2E5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic add_sym(input logic i, input logic q, input logic u);
        sym_t s;
        s.i = i; s.q = q; s.u = u; s.last = 1'b0;
        frame.push_back(s);
    endtask

    task automatic add_preamble();
        for (int p = 0; p < PRE; p++) add_sym(p % 2 == 0, p % 2 == 0, 1'b0);
    endtask

    // bits[n-1] is the first bit sent.
    task automatic build_std(input logic [31:0] bits, input int n);
        frame.delete();
        add_preamble();
        for (int k = 0; k + 1 < n; k += 2) add_sym(bits[n-1-k], bits[n-2-k], 1'b0);
        if (n % 2 == 1) add_sym(bits[0], 1'b0, 1'b0);
        for (int t = 0; t < TLEN; t++) add_sym(1'b0, 1'b0, 1'b0);
    endtask

    task automatic commit(input int upto);
        for (int k = 0; k < upto; k++) begin
            sym_t s;
            s = frame[k];
            s.last = (k == frame.size() - 1);
            sb.push_back(s);
        end
    endtask

    task automatic push_bits(input logic [31:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            bit_valid = 1'b1;
            bit_in    = bits[k];
            tick(1);
        end
        bit_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || msg_out) && n < 400) begin
            tick(1);
            n++;
        end
        check({name, "_drained"}, (sb.size() == 0 && !msg_out), 1);
    endtask

    // Monitor: pops the scoreboard on every strobe and checks frame envelope/spacing.
    int   cyc = 0;
    int   last_ns = 0;
    logic prev_mo = 1'b0;
    logic last_was_last = 1'b1;
    sym_t mon_e;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_mo       = 1'b0;
            last_was_last = 1'b1;
        end else begin
            if (new_symbol) begin
                if (sb.size() == 0) begin
                    check("unexpected_symbol", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("sym_iq", {data_in_i, data_in_q}, {mon_e.i, mon_e.q});
                    check("sym_underrun", underrun, mon_e.u);
                    check("sym_msg_out", msg_out, 1);
                    if (prev_mo) check("sym_spacing", cyc - last_ns, SPS);
                    last_ns       = cyc;
                    last_was_last = mon_e.last;
                end
            end
            if (msg_out && !prev_mo) check("frame_start_on_symbol", new_symbol, 1);
            if (!msg_out && prev_mo) check("frame_end_on_last", last_was_last, 1);
            prev_mo = msg_out;
        end
    end

    initial begin
        int seen;
        // Reset state
        #1;
        check("rst_new_symbol", new_symbol, 0);
        check("rst_msg_out", msg_out, 0);
        check("rst_data_i", data_in_i, 0);
        check("rst_data_q", data_in_q, 0);
        check("rst_underrun", underrun, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_bit_ready", bit_ready, 1);
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("post_rst_bit_ready", bit_ready, 1);

        // Basic frame: 1,0,1,1
        push_bits(32'b1011, 4);
        check("preload_count", fifo_count, 4);
        build_std(32'b1011, 4);
        commit(frame.size());
        msg_in = 1'b1; tick(1); msg_in = 1'b0;
        wait_drain("basic");
        check("basic_count", fifo_count, 0);
        check("basic_underrun", underrun, 0);

        // Underrun: msg_in held with empty FIFO, then 2 bits arrive
        frame.delete();
        add_preamble();
        add_sym(1'b0, 1'b0, 1'b1);
        add_sym(1'b1, 1'b0, 1'b1);
        add_sym(1'b0, 1'b0, 1'b1);
        add_sym(1'b0, 1'b0, 1'b1);
        commit(frame.size());
        msg_in = 1'b1;
        tick(2 + PRE * SPS);
        check("underrun_flag", underrun, 1);
        bit_valid = 1'b1; bit_in = 1'b1; tick(1);
        bit_in = 1'b0; tick(1);
        bit_valid = 1'b0; msg_in = 1'b0;
        wait_drain("underrun");
        check("underrun_sticky", underrun, 1);

        // Odd bit count: 1,1,0 (first symbol also shows underrun cleared)
        push_bits(32'b110, 3);
        build_std(32'b110, 3);
        commit(frame.size());
        msg_in = 1'b1; tick(1); msg_in = 1'b0;
        wait_drain("odd");
        check("odd_count", fifo_count, 0);

        // Full FIFO, overflow attempt, then push+pop in a slot cycle
        push_bits({16'h0, pat}, 16);
        check("full_count", fifo_count, 16);
        check("full_ready", bit_ready, 0);
        bit_valid = 1'b1; bit_in = 1'b1; tick(1); bit_valid = 1'b0;
        check("overflow_count", fifo_count, 16);
        build_std({14'h0, pat, 2'b10}, 18);
        commit(frame.size());
        msg_in = 1'b1; tick(1); msg_in = 1'b0;
        tick(1 + PRE * SPS);
        check("first_pop_count", fifo_count, 14);
        bit_valid = 1'b1; bit_in = 1'b1; tick(1); bit_valid = 1'b0;
        tick(SPS - 2);
        check("pre_slot_count", fifo_count, 15);
        bit_valid = 1'b1; bit_in = 1'b0; tick(1); bit_valid = 1'b0;
        check("push_pop_count", fifo_count, 14);
        wait_drain("full");
        check("full_end_count", fifo_count, 0);

        // Back-to-back frames
        push_bits(32'b01, 2);
        build_std(32'b01, 2);
        commit(frame.size());
        frame.delete();
        add_preamble();
        add_sym(1'b0, 1'b0, 1'b0);
        add_sym(1'b0, 1'b0, 1'b0);
        commit(frame.size());
        msg_in = 1'b1; tick(1); msg_in = 1'b0;
        tick(1 + (PRE + 1) * SPS);
        msg_in = 1'b1;
        tick(SPS);
        check("b2b_last_symbol", new_symbol, 1);
        tick(1);
        msg_in = 1'b0;
        check("b2b_gap_msg_out", msg_out, 0);
        tick(1);
        check("b2b_restart_strobe", new_symbol, 1);
        check("b2b_restart_msg_out", msg_out, 1);
        wait_drain("b2b");

        // Reset mid-frame
        push_bits(32'b110110, 6);
        build_std(32'b110110, 6);
        commit(2);
        msg_in = 1'b1; tick(1); msg_in = 1'b0;
        tick(1 + SPS);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_new_symbol", new_symbol, 0);
        check("midrst_msg_out", msg_out, 0);
        check("midrst_data_q", data_in_q, 0);
        check("midrst_fifo_count", fifo_count, 0);
        check("midrst_bit_ready", bit_ready, 1);
        tick(2);
        rst_n = 1'b1;
        seen = 0;
        repeat (3 * SPS) begin
            tick(1);
            if (new_symbol) seen++;
        end
        check("no_symbol_after_reset", seen, 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
